// File: rtl/alu_exec_if.sv
// Request/result handshake bundle for alu_exec.
// The slave modport is the ALU side; master is the requester/consumer side.
interface alu_exec_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            valid_i;
  logic            ready_o;
  logic [3:0]      ALUCtrl_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            branch_o;

  modport master (
    output valid_i,
    output ALUCtrl_i,
    output src1_i,
    output src2_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  result_o,
    input  branch_o
  );

  modport slave (
    input  valid_i,
    input  ALUCtrl_i,
    input  src1_i,
    input  src2_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output result_o,
    output branch_o
  );

endinterface

// File: rtl/alu_exec.sv
// Single-issue ALU with valid/ready handshakes on both sides. Non-shift ops finish in one
// cycle; shifts by N>0 walk a one-bit-per-cycle shifter for N cycles before presenting.
module alu_exec #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpSlt = 4'd4;
  localparam logic [3:0] OpBeq = 4'd5;
  localparam logic [3:0] OpSll = 4'd6;
  localparam logic [3:0] OpSrl = 4'd7;
  localparam logic [3:0] OpSra = 4'd8;
  localparam logic [3:0] OpBne = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } stateT;

  stateT           stateQ, stateD;
  logic [3:0]      opQ, opD;
  logic [XLEN-1:0] shiftRegQ, shiftRegD;
  logic [4:0]      cntQ, cntD;
  logic [XLEN-1:0] resultQ, resultD;
  logic            branchQ, branchD;

  logic [4:0]      shamt;
  logic            isShift;
  logic [XLEN-1:0] aluResult;
  logic            aluBranch;
  logic [XLEN-1:0] shiftStep;

  // Upper src2 bits never influence the shift amount.
  assign shamt   = bus.src2_i[4:0];
  assign isShift = (bus.ALUCtrl_i == OpSll) || (bus.ALUCtrl_i == OpSrl) ||
                   (bus.ALUCtrl_i == OpSra);

  // Single-cycle datapath evaluated on the live request inputs at the accepting edge.
  always_comb begin
    aluResult = '0;
    aluBranch = 1'b0;
    unique case (bus.ALUCtrl_i)
      OpAdd: aluResult = bus.src1_i + bus.src2_i;
      OpSub: aluResult = bus.src1_i - bus.src2_i;
      OpAnd: aluResult = bus.src1_i & bus.src2_i;
      OpOr:  aluResult = bus.src1_i | bus.src2_i;
      OpSlt: aluResult = {{(XLEN-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OpBeq: begin
        aluResult = bus.src1_i ^ bus.src2_i;
        aluBranch = (bus.src1_i == bus.src2_i);
      end
      OpBne: begin
        aluResult = bus.src1_i ^ bus.src2_i;
        aluBranch = (bus.src1_i != bus.src2_i);
      end
      // Only reached with a zero shift amount; nonzero amounts go through StShift.
      OpSll, OpSrl, OpSra: aluResult = bus.src1_i;
      default: begin
        aluResult = '0;
        aluBranch = 1'b0;
      end
    endcase
  end

  always_comb begin
    shiftStep = shiftRegQ;
    unique case (opQ)
      OpSll:   shiftStep = {shiftRegQ[XLEN-2:0], 1'b0};
      OpSrl:   shiftStep = {1'b0, shiftRegQ[XLEN-1:1]};
      OpSra:   shiftStep = {shiftRegQ[XLEN-1], shiftRegQ[XLEN-1:1]};
      default: shiftStep = shiftRegQ;
    endcase
  end

  always_comb begin
    stateD    = stateQ;
    opD       = opQ;
    shiftRegD = shiftRegQ;
    cntD      = cntQ;
    resultD   = resultQ;
    branchD   = branchQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.valid_i) begin
          opD       = bus.ALUCtrl_i;
          shiftRegD = bus.src1_i;
          cntD      = shamt;
          if (isShift && (shamt != 5'd0)) begin
            stateD = StShift;
          end else begin
            resultD = aluResult;
            branchD = aluBranch;
            stateD  = StDone;
          end
        end
      end
      StShift: begin
        shiftRegD = shiftStep;
        cntD      = cntQ - 5'd1;
        if (cntQ == 5'd1) begin
          resultD = shiftStep;
          branchD = 1'b0;
          stateD  = StDone;
        end
      end
      StDone: begin
        if (bus.ready_i) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ    <= StIdle;
      opQ       <= 4'd0;
      shiftRegQ <= '0;
      cntQ      <= 5'd0;
      resultQ   <= '0;
      branchQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      opQ       <= opD;
      shiftRegQ <= shiftRegD;
      cntQ      <= cntD;
      resultQ   <= resultD;
      branchQ   <= branchD;
    end
  end

  // ready_o is masked by reset so nothing is accepted while reset is held.
  assign bus.ready_o  = (stateQ == StIdle) && !rst_i;
  assign bus.valid_o  = (stateQ == StDone);
  assign bus.result_o = resultQ;
  assign bus.branch_o = branchQ;

  assert property (@(posedge clk_i) disable iff (rst_i)
    (stateQ == StDone && !bus.ready_i) |=> ($stable(resultQ) && $stable(branchQ)));

  assert property (@(posedge clk_i) disable iff (rst_i)
    (stateQ == StShift) |-> (cntQ != 5'd0));

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus randomized traffic checked
// against an arithmetic reference model.
module tb_alu_exec;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_exec_if #(.XLEN(XLEN)) aluBus ();

  alu_exec #(.XLEN(XLEN)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (aluBus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {branch, result} straight from the operation table.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    int                 amt;
    sa  = a;
    amt = int'(b % 32);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, (sa < $signed(b)) ? 32'd1 : 32'd0};
      4'd5:    return {(a == b), a ^ b};
      4'd6:    return {1'b0, a << amt};
      4'd7:    return {1'b0, a >> amt};
      4'd8:    return {1'b0, 32'(sa >>> amt)};
      4'd9:    return {(a != b), a ^ b};
      default: return 33'd0;
    endcase
  endfunction

  function automatic int modelLatency(input logic [3:0] op, input logic [31:0] b);
    int amt;
    amt = int'(b % 32);
    if (op >= 4'd6 && op <= 4'd8 && amt > 0) return amt + 1;
    return 1;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Presents one request; returns one cycle after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!aluBus.ready_o && n < 50) begin
      stepClk();
      n++;
    end
    aluBus.valid_i   = 1'b1;
    aluBus.ALUCtrl_i = op;
    aluBus.src1_i    = a;
    aluBus.src2_i    = b;
    stepClk();
    aluBus.valid_i   = 1'b0;
    aluBus.ALUCtrl_i = 4'($urandom);
    aluBus.src1_i    = $urandom;
    aluBus.src2_i    = $urandom;
  endtask

  // lat counts cycles after acceptance until valid_o (-1 if it never came).
  task automatic waitValid(input bit jiggleReady, output int lat, output bit readyLow);
    lat      = 1;
    readyLow = !aluBus.ready_o;
    while (!aluBus.valid_o && lat < 64) begin
      if (jiggleReady) aluBus.ready_i = 1'($urandom);
      stepClk();
      lat++;
      if (aluBus.ready_o) readyLow = 1'b0;
    end
    if (!aluBus.valid_o) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aluBus.valid_i = 1'b0;
    aluBus.ready_i = 1'b0;
    aluBus.ALUCtrl_i = 4'd0;
    aluBus.src1_i = '0;
    aluBus.src2_i = '0;
    repeat (3) stepClk();
    checks++;
    if (aluBus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset ready_o: got %b expected 0", aluBus.ready_o);
    end
    checks++;
    if ({aluBus.valid_o, aluBus.branch_o, aluBus.result_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset outputs: got valid=%b branch=%b result=%h expected all 0",
               aluBus.valid_o, aluBus.branch_o, aluBus.result_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (aluBus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset release ready_o: got %b expected 1", aluBus.ready_o);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    bit rl;
    aluBus.ready_i = 1'b1;
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    waitValid(1'b0, lat, rl);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL add_wrap latency: got %0d expected 1", lat);
    end
    checks++;
    if (aluBus.result_o !== 32'h0000_0001 || aluBus.branch_o !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap result: got %h/%b expected 00000001/0",
               aluBus.result_o, aluBus.branch_o);
    end
    stepClk();
  endtask

  task automatic test_branches();
    int lat;
    bit rl;
    aluBus.ready_i = 1'b1;
    issue(4'd5, 32'h0000_1234, 32'h0000_1234);
    waitValid(1'b0, lat, rl);
    checks++;
    if (lat != 1 || aluBus.branch_o !== 1'b1 || aluBus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL beq: got lat=%0d branch=%b result=%h expected 1/1/00000000",
               lat, aluBus.branch_o, aluBus.result_o);
    end
    stepClk();
    issue(4'd9, 32'h0000_1234, 32'h0000_1235);
    waitValid(1'b0, lat, rl);
    checks++;
    if (lat != 1 || aluBus.branch_o !== 1'b1 || aluBus.result_o !== 32'h0000_0001) begin
      errors++;
      $display("FAIL bne: got lat=%0d branch=%b result=%h expected 1/1/00000001",
               lat, aluBus.branch_o, aluBus.result_o);
    end
    stepClk();
  endtask

  task automatic test_sra_latency();
    int lat;
    bit rl;
    issue(4'd8, 32'h8000_0000, 32'h0000_0024);
    waitValid(1'b1, lat, rl);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL sra latency: got %0d expected 5", lat);
    end
    checks++;
    if (rl !== 1'b1) begin
      errors++;
      $display("FAIL sra ready_o: got high during operation expected low");
    end
    checks++;
    if (aluBus.result_o !== 32'hF800_0000 || aluBus.branch_o !== 1'b0) begin
      errors++;
      $display("FAIL sra result: got %h/%b expected f8000000/0",
               aluBus.result_o, aluBus.branch_o);
    end
    aluBus.ready_i = 1'b1;
    stepClk();
  endtask

  task automatic test_undefined_zero_shift();
    int lat;
    bit rl;
    aluBus.ready_i = 1'b1;
    issue(4'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    waitValid(1'b0, lat, rl);
    checks++;
    if (lat != 1 || aluBus.result_o !== 32'd0 || aluBus.branch_o !== 1'b0) begin
      errors++;
      $display("FAIL undefined op: got lat=%0d result=%h branch=%b expected 1/00000000/0",
               lat, aluBus.result_o, aluBus.branch_o);
    end
    stepClk();
    issue(4'd7, 32'h0000_00A5, 32'hFFFF_FFE0);
    waitValid(1'b0, lat, rl);
    checks++;
    if (lat != 1 || aluBus.result_o !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL zero shift: got lat=%0d result=%h expected 1/000000a5",
               lat, aluBus.result_o);
    end
    stepClk();
  endtask

  task automatic test_backpressure();
    int lat;
    bit rl;
    bit held;
    aluBus.ready_i = 1'b0;
    issue(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
    waitValid(1'b0, lat, rl);
    held = (lat == 1);
    for (int i = 0; i < 4; i++) begin
      if (aluBus.valid_o !== 1'b1 || aluBus.result_o !== 32'h1 || aluBus.branch_o !== 1'b0)
        held = 1'b0;
      if (aluBus.ready_o !== 1'b0) held = 1'b0;
      aluBus.ready_i = (i == 3);
      stepClk();
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL backpressure hold: got lat=%0d or unstable result expected 00000001 x4",
               lat);
    end
    checks++;
    if (aluBus.valid_o !== 1'b0 || aluBus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: got valid=%b ready=%b expected 0/1",
               aluBus.valid_o, aluBus.ready_o);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit sawValid;
    issue(4'd6, 32'h0000_0F0F, 32'd20);
    sawValid = aluBus.valid_o;
    repeat (4) begin
      aluBus.ready_i = 1'b1;
      stepClk();
      if (aluBus.valid_o) sawValid = 1'b1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (aluBus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midshift ready during reset: got %b expected 0", aluBus.ready_o);
    end
    stepClk();
    rst = 1'b0;
    #1;
    checks++;
    if (aluBus.ready_o !== 1'b1 || aluBus.result_o !== 32'd0 || aluBus.branch_o !== 1'b0) begin
      errors++;
      $display("FAIL midshift after reset: got ready=%b result=%h branch=%b expected 1/0/0",
               aluBus.ready_o, aluBus.result_o, aluBus.branch_o);
    end
    repeat (25) begin
      stepClk();
      if (aluBus.valid_o) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("FAIL midshift valid_o: got a valid pulse expected none");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    aluBus.ready_i   = 1'b1;
    aluBus.valid_i   = 1'b1;
    aluBus.ALUCtrl_i = 4'd0;
    aluBus.src1_i    = a1;
    aluBus.src2_i    = b1;
    stepClk();
    aluBus.src1_i = a2;
    aluBus.src2_i = b2;
    checks++;
    if (aluBus.valid_o !== 1'b1 || aluBus.result_o !== a1 + b1) begin
      errors++;
      $display("FAIL b2b first: got valid=%b result=%h expected 1/%h",
               aluBus.valid_o, aluBus.result_o, a1 + b1);
    end
    stepClk();
    checks++;
    if (aluBus.valid_o !== 1'b0 || aluBus.ready_o !== 1'b1 || aluBus.result_o !== a1 + b1) begin
      errors++;
      $display("FAIL b2b gap: got valid=%b ready=%b result=%h expected 0/1/%h",
               aluBus.valid_o, aluBus.ready_o, aluBus.result_o, a1 + b1);
    end
    stepClk();
    aluBus.valid_i = 1'b0;
    checks++;
    if (aluBus.valid_o !== 1'b1 || aluBus.result_o !== a2 + b2) begin
      errors++;
      $display("FAIL b2b second: got valid=%b result=%h expected 1/%h",
               aluBus.valid_o, aluBus.result_o, a2 + b2);
    end
    stepClk();
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [32:0] exp;
    int          expLat, lat, stall;
    bit          rl, held;
    for (int t = 0; t < 40; t++) begin
      op     = 4'($urandom_range(0, 15));
      a      = $urandom;
      b      = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exp    = model(op, a, b);
      expLat = modelLatency(op, b);
      stall  = $urandom_range(0, 3);
      issue(op, a, b);
      waitValid(1'b1, lat, rl);
      checks++;
      if (lat != expLat || rl !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d latency op=%0d: got %0d readyLow=%b expected %0d readyLow=1",
                 t, op, lat, rl, expLat);
      end
      checks++;
      if ({aluBus.branch_o, aluBus.result_o} !== exp) begin
        errors++;
        $display("FAIL rand%0d result op=%0d a=%h b=%h: got %b/%h expected %b/%h", t, op, a, b,
                 aluBus.branch_o, aluBus.result_o, exp[32], exp[31:0]);
      end
      held = 1'b1;
      for (int s = 0; s < stall; s++) begin
        aluBus.ready_i = 1'b0;
        aluBus.valid_i = 1'($urandom);
        stepClk();
        if (aluBus.valid_o !== 1'b1 || {aluBus.branch_o, aluBus.result_o} !== exp) held = 1'b0;
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL rand%0d hold: got changing result under stall expected %h", t, exp);
      end
      aluBus.ready_i = 1'b1;
      aluBus.valid_i = 1'($urandom);
      stepClk();
      aluBus.valid_i = 1'b0;
      checks++;
      if (aluBus.valid_o !== 1'b0 || aluBus.ready_o !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d release: got valid=%b ready=%b expected 0/1",
                 t, aluBus.valid_o, aluBus.ready_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_branches();
    test_sra_latency();
    test_undefined_zero_shift();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-003 clk_i  input  1  rising-edge clock for all state.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 valid_i  input  1  operation request present.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 ALUCtrl_i  input  4  operation code.
REQ-008 src1_i  input  XLEN  operand 1.
REQ-009 src2_i  input  XLEN  operand 2; bits [4:0] are the shift amount for shifts.
REQ-010 valid_o  output  1  result_o and branch_o are valid.
REQ-011 ready_i  input  1  consumer accepts the result.
REQ-012 result_o  output  XLEN  operation result.
REQ-013 branch_o  output  1  branch-taken flag; meaningful for codes 5 and 9 only.

Function
REQ-014 ALUCtrl_i encoding SHALL be:
- 0 = add
- 1 = sub
- 2 = and
- 3 = or
- 4 = signed slt (result 1/0)
- 5 = xor/BEQ
- 6 = sll
- 7 = srl
- 8 = sra
- 9 = BNE (result = src1 xor src2)
- 10-15 = result 0, branch_o 0.
REQ-015 Add and sub SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-016 branch_o SHALL be (src1==src2) for code 5, (src1!=src2) for code 9, and 0 for all other codes.
REQ-017 The FSM SHALL have three states:
- IDLE: ready_o=1, valid_o=0.
- SHIFT: ready_o=0, valid_o=0.
- DONE: ready_o=0, valid_o=1.
REQ-018 A request SHALL be accepted on a rising edge where valid_i=1 and ready_o=1; the operands and code SHALL be captured at that edge, and the inputs are don't-care at all other times.
REQ-019 After acceptance, non-shift codes and shifts with amount 0 SHALL go IDLE->DONE with the result registered: valid_o=1 in the cycle after acceptance (latency 1).
REQ-020 Shift codes 6/7/8 with amount N>0 SHALL go IDLE->SHIFT:
- shift the captured operand by one bit per cycle in SHIFT;
- fill with 0 for sll/srl and with the sign bit for sra;
- move to DONE after N SHIFT cycles, so valid_o rises N+1 cycles after acceptance.
REQ-021 Only src2_i[4:0] SHALL be used as the shift amount; src2_i bits [XLEN-1:5] are ignored for shifts.
REQ-022 In DONE, result_o and branch_o SHALL be held stable while ready_i=0.
REQ-023 DONE->IDLE SHALL occur on an edge with ready_i=1; valid_o deasserts the next cycle.
REQ-024 A new request SHALL NOT be accepted in the DONE cycle itself; the minimum spacing between acceptances is 2 cycles.
REQ-025 ready_i SHALL be ignored outside DONE; valid_i SHALL be ignored outside IDLE.
REQ-026 result_o and branch_o SHALL retain their last values in IDLE and SHIFT.

Reset
REQ-027 With rst_i=1 at an edge, the block SHALL go to IDLE and set valid_o=0, result_o=0, branch_o=0 and the shift counter to 0.
REQ-028 ready_o SHALL be 0 while rst_i=1 and 1 in the first cycle after rst_i deasserts.
REQ-029 Reset SHALL take priority over acceptance, shifting and the DONE handshake.
REQ-030 Reset during SHIFT or DONE SHALL discard the operation; no valid_o pulse follows.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Add wrap: code 0, src1=0xFFFFFFFF, src2=0x00000002, ready_i=1 -> one cycle later valid_o=1, result_o=0x00000001, branch_o=0.
- Branches: code 5, src1=src2=0x1234 -> branch_o=1, result_o=0; code 9, src1=0x1234, src2=0x1235 -> branch_o=1, result_o=0x00000001.
- SRA latency: code 8, src1=0x80000000, src2=0x00000024 (amount 4) -> valid_o rises 5 cycles after acceptance, result_o=0xF8000000, ready_o=0 throughout.
- Backpressure: code 4, src1=0xFFFFFFFF, src2=0x1, ready_i=0 for 3 cycles then 1 -> result_o=0x1 held 4 cycles; ready_o returns to 1 the cycle after the handshake.
- Reset mid-shift: code 6, amount 20, rst_i pulsed 5 cycles after acceptance -> valid_o never asserts, result_o=0, ready_o=1 one cycle after reset release.
- Undefined and zero-shift codes: code 12 -> result_o=0, branch_o=0, latency 1; code 7 with amount 0, src1=0xA5 -> result_o=0xA5, latency 1.
